uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 115 +++++++++++
 tb/tb_uart_tx_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small FIFO; frames go out back-to-back while bytes are queued.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic [DATA_BITS-1:0]          i_TX_Byte,
    input  logic                          i_DV,
    output logic                          o_Ready,
    output logic                          o_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
    output logic                          o_Busy,
    output logic                          o_TX_Serial
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state, next;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic [CW-1:0]        clk_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit, pop, wr, clk_done, last_data, last_stop, line;

    assign o_Ready      = count != (AW+1)'(FIFO_DEPTH);
    assign o_FIFO_Count = count;
    assign wr           = i_DV && o_Ready;
    assign clk_done     = clk_cnt == CW'(CLKS_PER_BIT - 1);
    assign last_data    = bit_cnt == 3'(DATA_BITS - 1);
    assign last_stop    = bit_cnt == 3'(STOP_BITS - 1);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) state <= S_IDLE;
        else         state <= next;
    end

    // Popping in the last stop cycle lets the next start bit follow with no idle gap.
    always_comb begin
        next = state;
        pop  = 1'b0;
        case (state)
            S_IDLE:   if (|count) begin
                          next = S_START;
                          pop  = 1'b1;
                      end
            S_START:  if (clk_done) next = S_DATA;
            S_DATA:   if (clk_done && last_data) next = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (clk_done) next = S_STOP;
            S_STOP:   if (clk_done && last_stop) begin
                          next = |count ? S_START : S_IDLE;
                          pop  = |count;
                      end
            default:  next = S_IDLE;
        endcase
        line = (state == S_START)  ? 1'b0 :
               (state == S_DATA)   ? shift[0] :
               (state == S_PARITY) ? par_bit : 1'b1;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            clk_cnt <= (state == S_IDLE || clk_done) ? '0 : clk_cnt + 1'b1;
            if (state != S_DATA && state != S_STOP)
                bit_cnt <= '0;
            else if (clk_done)
                bit_cnt <= ((state == S_DATA) ? last_data : last_stop) ? '0 : bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (wr && !i_Reset) mem[wr_ptr] <= i_TX_Byte;
        if (pop) begin
            shift   <= mem[rd_ptr];
            par_bit <= (PARITY == 2) ^ (^mem[rd_ptr]);
        end else if (state == S_DATA && clk_done) begin
            shift <= shift >> 1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_Overflow <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(wr);
            rd_ptr     <= rd_ptr + AW'(pop);
            count      <= count + (AW+1)'(wr) - (AW+1)'(pop);
            o_Overflow <= i_DV && !o_Ready;
        end
    end

    // Line and busy are registered together so busy covers exactly the bits on the wire.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_TX_Serial <= 1'b1;
            o_Busy      <= 1'b0;
        end else begin
            o_TX_Serial <= line;
            o_Busy      <= state != S_IDLE;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: four parameterisations checked cycle by cycle against a queue-based frame model.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [3:0]      dv, ser, busy, rdy, ovf;
    logic [3:0][7:0] din;
    logic [3:0][2:0] cnt;
    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(4)) d0 (
        .i_Clock(clk), .i_Reset(rst), .i_TX_Byte(din[0]), .i_DV(dv[0]), .o_Ready(rdy[0]),
        .o_Overflow(ovf[0]), .o_FIFO_Count(cnt[0]), .o_Busy(busy[0]), .o_TX_Serial(ser[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) d1 (
        .i_Clock(clk), .i_Reset(rst), .i_TX_Byte(din[1]), .i_DV(dv[1]), .o_Ready(rdy[1]),
        .o_Overflow(ovf[1]), .o_FIFO_Count(cnt[1]), .o_Busy(busy[1]), .o_TX_Serial(ser[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) d2 (
        .i_Clock(clk), .i_Reset(rst), .i_TX_Byte(din[2]), .i_DV(dv[2]), .o_Ready(rdy[2]),
        .o_Overflow(ovf[2]), .o_FIFO_Count(cnt[2]), .o_Busy(busy[2]), .o_TX_Serial(ser[2]));
    uart_tx_fifo #(.CLKS_PER_BIT(3), .DATA_BITS(5)) d3 (
        .i_Clock(clk), .i_Reset(rst), .i_TX_Byte(din[3][4:0]), .i_DV(dv[3]), .o_Ready(rdy[3]),
        .o_Overflow(ovf[3]), .o_FIFO_Count(cnt[3]), .o_Busy(busy[3]), .o_TX_Serial(ser[3]));

    function automatic int db(input int i); return (i == 3) ? 5 : 8; endfunction
    function automatic int cb(input int i); return (i == 3) ? 3 : 4; endfunction
    function automatic int pm(input int i); return (i == 1) ? 1 : (i == 2) ? 2 : 0; endfunction
    function automatic int sb(input int i); return (i == 1 || i == 2) ? 2 : 1; endfunction
    function automatic int nb(input int i); return 1 + db(i) + (pm(i) != 0 ? 1 : 0) + sb(i); endfunction

    function automatic bit frame_bit(input int i, input logic [7:0] b, input int k);
        bit p = 1'b0;
        for (int j = 0; j < db(i); j++) p ^= b[j];
        if (pm(i) == 2) p = ~p;
        if (k == 0) return 1'b0;
        if (k <= db(i)) return b[k-1];
        if (pm(i) != 0 && k == db(i) + 1) return p;
        return 1'b1;
    endfunction

    // Spec-level model: a frame starts on the line at max(previous frame end, write edge + 2).
    task automatic run_seq(input int i, input logic [8:0] stim[$], input int n, output logic cap[$]);
        logic [7:0] q[$];
        bit exp_line[int];
        int next_free = 0;
        bit rdy_m, ovf_m, el, eb;
        logic [7:0] b;
        cap = {};
        for (int t = 0; t < n; t++) begin
            dv[i]  = (t < stim.size()) ? stim[t][8] : 1'b0;
            din[i] = (t < stim.size()) ? stim[t][7:0] : 8'h00;
            rdy_m  = q.size() < 4;
            if (q.size() > 0 && t + 1 >= next_free) begin
                b = q.pop_front();
                for (int c = 0; c < nb(i) * cb(i); c++) exp_line[t+1+c] = frame_bit(i, b, c / cb(i));
                next_free = t + 1 + nb(i) * cb(i);
            end
            ovf_m = dv[i] && !rdy_m;
            if (dv[i] && rdy_m) q.push_back(din[i]);
            @(negedge clk);
            eb = exp_line.exists(t);
            el = eb ? exp_line[t] : 1'b1;
            cap.push_back(ser[i]);
            n_checks += 5;
            if (ser[i] !== el) begin
                n_fail++;
                $display("FAIL line[%0d] t=%0d: got %b expected %b", i, t, ser[i], el);
            end
            if (busy[i] !== eb) begin
                n_fail++;
                $display("FAIL busy[%0d] t=%0d: got %b expected %b", i, t, busy[i], eb);
            end
            if (cnt[i] !== 3'(q.size())) begin
                n_fail++;
                $display("FAIL count[%0d] t=%0d: got %0d expected %0d", i, t, cnt[i], q.size());
            end
            if (rdy[i] !== (q.size() < 4)) begin
                n_fail++;
                $display("FAIL ready[%0d] t=%0d: got %b expected %b", i, t, rdy[i], q.size() < 4);
            end
            if (ovf[i] !== ovf_m) begin
                n_fail++;
                $display("FAIL overflow[%0d] t=%0d: got %b expected %b", i, t, ovf[i], ovf_m);
            end
        end
        dv[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dv  = '1;
        din = {8'h5A, 8'hC3, 8'h11, 8'hFF};
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({ser[i], busy[i], rdy[i], ovf[i], cnt[i]} !== 7'b1010_000) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got ser/busy/rdy/ovf/cnt %b%b%b%b/%0d expected 1010/0",
                         i, ser[i], busy[i], rdy[i], ovf[i], cnt[i]);
            end
        end
        rst = 1'b0;
        dv  = '0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cnt[i] !== 3'd0 || ser[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_writes_ignored[%0d]: got cnt %0d line %b expected 0 1", i, cnt[i], ser[i]);
            end
        end
    endtask

    task automatic test_a5();
        logic [8:0] s[$];
        logic cap[$];
        logic [9:0] got;
        s = '{9'h1A5};
        run_seq(0, s, 50, cap);
        for (int k = 0; k < 10; k++) got[k] = cap[2 + 4*k + 1];
        n_checks += 2;
        if (got !== 10'b1101001010) begin
            n_fail++;
            $display("FAIL a5_bits: got %b expected %b", got, 10'b1101001010);
        end
        if (cap[1] !== 1'b1 || cap[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL latency: got line %b%b at t1,t2 expected 10", cap[1], cap[2]);
        end
    endtask

    task automatic test_parity();
        logic [8:0] s[$];
        logic cap[$];
        logic [11:0] got, exp;
        s = '{9'h107};
        for (int i = 1; i <= 2; i++) begin
            run_seq(i, s, 60, cap);
            for (int k = 0; k < 12; k++) got[k] = cap[2 + 4*k + 1];
            exp = (i == 1) ? 12'hE0E : 12'hC0E;
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL parity_frame[%0d]: got %b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_5bit();
        logic [8:0] s[$];
        logic cap[$];
        logic [6:0] got;
        s = '{9'h113};
        run_seq(3, s, 40, cap);
        for (int k = 0; k < 7; k++) got[k] = cap[2 + 3*k + 1];
        n_checks++;
        if (got !== 7'b1100110) begin
            n_fail++;
            $display("FAIL five_bit_frame: got %b expected %b", got, 7'b1100110);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] s[$];
        logic cap[$];
        s = '{9'h101, 9'h102, 9'h103, 9'h104, 9'h105, 9'h106};
        run_seq(0, s, 216, cap);
    endtask

    task automatic test_full_pop();
        logic [8:0] s[$];
        logic cap[$];
        for (int t = 0; t < 42; t++) s.push_back((t < 5) ? 9'(9'h1F0 + t) : (t == 41) ? 9'h155 : 9'h000);
        run_seq(0, s, 252, cap);
    endtask

    task automatic test_reset_mid_frame();
        bit quiet = 1'b1;
        for (int t = 0; t < 16; t++) begin
            dv[0]  = t < 3;
            din[0] = (t == 0) ? 8'hAA : 8'(8'h30 + t);
            rst    = (t == 15);
            @(negedge clk);
            if (t == 14) begin
                n_checks++;
                if (busy[0] !== 1'b1 || cnt[0] !== 3'd2 || ser[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pre_reset: got busy %b cnt %0d line %b expected 1 2 0", busy[0], cnt[0], ser[0]);
                end
            end
        end
        rst = 1'b0;
        n_checks++;
        if ({ser[0], busy[0], rdy[0], ovf[0], cnt[0]} !== 7'b1010_000) begin
            n_fail++;
            $display("FAIL mid_reset: got ser/busy/rdy/ovf/cnt %b%b%b%b/%0d expected 1010/0",
                     ser[0], busy[0], rdy[0], ovf[0], cnt[0]);
        end
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (ser[0] !== 1'b1 || busy[0] !== 1'b0 || cnt[0] !== 3'd0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL after_reset_quiet: got activity expected idle line");
        end
    endtask

    task automatic test_random();
        logic [8:0] s[$];
        logic cap[$];
        for (int i = 0; i < 4; i++) begin
            s = {};
            for (int t = 0; t < 120; t++) s.push_back({($urandom_range(0, 2) == 0), 8'($urandom)});
            run_seq(i, s, 120 + 5 * nb(i) * cb(i) + 10, cap);
        end
    endtask

    initial begin
        rst = 1'b1;
        dv  = '0;
        din = '0;
        test_reset();
        test_a5();
        test_parity();
        test_5bit();
        test_back_to_back();
        test_full_pop();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
